// File: rtl/load_store_unit_if.sv
// Request, data-RAM, writeback and fault bundle of the load/store unit.
// The slave side is the LSU; the master side is execute/memory/writeback.
interface load_store_unit_if #(
  parameter int ADDR_W = 17
);
  logic              req_valid;
  logic              req_ready;
  logic [5:0]        alucode;
  logic [31:0]       addr;
  logic [31:0]       store_data;
  logic [4:0]        rd;
  logic              dmem_en;
  logic [3:0]        dmem_we;
  logic [ADDR_W-3:0] dmem_addr;
  logic [31:0]       dmem_wdata;
  logic [31:0]       dmem_rdata;
  logic              wb_valid;
  logic              wb_ready;
  logic [31:0]       wb_data;
  logic [4:0]        wb_rd;
  logic              fault_valid;
  logic              fault_store;
  logic [31:0]       fault_addr;

  modport master (
    output req_valid, alucode, addr, store_data, rd,
    output dmem_rdata, wb_ready,
    input  req_ready, dmem_en, dmem_we, dmem_addr, dmem_wdata,
    input  wb_valid, wb_data, wb_rd,
    input  fault_valid, fault_store, fault_addr
  );

  modport slave (
    input  req_valid, alucode, addr, store_data, rd,
    input  dmem_rdata, wb_ready,
    output req_ready, dmem_en, dmem_we, dmem_addr, dmem_wdata,
    output wb_valid, wb_data, wb_rd,
    output fault_valid, fault_store, fault_addr
  );
endinterface

// File: rtl/load_store_unit.sv
// RV32I load/store unit: alignment/range check, byte-lane RAM access,
// and a registered, sign/zero-extended load writeback response.
module load_store_unit #(
  parameter int ADDR_W = 17
) (
  input  logic clk,
  input  logic rst_n,
  load_store_unit_if.slave bus
);
  localparam logic [5:0] ALU_LB  = 6'd16;
  localparam logic [5:0] ALU_LH  = 6'd17;
  localparam logic [5:0] ALU_LW  = 6'd18;
  localparam logic [5:0] ALU_LBU = 6'd19;
  localparam logic [5:0] ALU_LHU = 6'd20;
  localparam logic [5:0] ALU_SB  = 6'd21;
  localparam logic [5:0] ALU_SH  = 6'd22;
  localparam logic [5:0] ALU_SW  = 6'd23;

  typedef enum logic [1:0] {
    IDLE,
    LOAD_WAIT,
    RESP
  } state_t;

  state_t      state;
  logic [5:0]  op_q;
  logic [1:0]  off_q;
  logic [4:0]  rd_q;
  logic        wb_valid_q;
  logic [31:0] wb_data_q;
  logic [4:0]  wb_rd_q;
  logic        fault_valid_q;
  logic        fault_store_q;
  logic [31:0] fault_addr_q;

  logic is_b, is_h, is_w, is_ld, is_st;
  logic misal, oor, bad, acc, go_ld, go_st;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic [31:0] sh;
  logic [31:0] ext;

  always_comb begin
    is_b  = 1'b0;
    is_h  = 1'b0;
    is_w  = 1'b0;
    is_ld = 1'b0;
    is_st = 1'b0;
    case (bus.alucode)
      ALU_LB:  begin is_ld = 1'b1; is_b = 1'b1; end
      ALU_LBU: begin is_ld = 1'b1; is_b = 1'b1; end
      ALU_LH:  begin is_ld = 1'b1; is_h = 1'b1; end
      ALU_LHU: begin is_ld = 1'b1; is_h = 1'b1; end
      ALU_LW:  begin is_ld = 1'b1; is_w = 1'b1; end
      ALU_SB:  begin is_st = 1'b1; is_b = 1'b1; end
      ALU_SH:  begin is_st = 1'b1; is_h = 1'b1; end
      ALU_SW:  begin is_st = 1'b1; is_w = 1'b1; end
      default: ;
    endcase
  end

  assign misal = (is_h && bus.addr[0])
              || (is_w && (bus.addr[1:0] != 2'b00));
  assign oor   = |bus.addr[31:ADDR_W];
  assign bad   = (is_ld || is_st) && (misal || oor);

  assign bus.req_ready = rst_n
    && (state == IDLE || (state == RESP && bus.wb_ready));
  assign acc   = bus.req_valid && bus.req_ready;
  assign go_ld = acc && is_ld && !bad;
  assign go_st = acc && is_st && !bad;

  always_comb begin
    be    = 4'b0000;
    wdata = 32'h0;
    if (go_st) begin
      unique case (1'b1)
        is_b: begin
          be    = 4'b0001 << bus.addr[1:0];
          wdata = {4{bus.store_data[7:0]}};
        end
        is_h: begin
          be    = 4'b0011 << bus.addr[1:0];
          wdata = {2{bus.store_data[15:0]}};
        end
        default: begin
          be    = 4'b1111;
          wdata = bus.store_data;
        end
      endcase
    end
  end

  assign bus.dmem_en    = go_ld || go_st;
  assign bus.dmem_we    = be;
  assign bus.dmem_wdata = wdata;
  assign bus.dmem_addr  = bus.dmem_en ? bus.addr[ADDR_W-1:2] : '0;

  // Move the addressed lane down to bit 0, then extend per opcode.
  assign sh = bus.dmem_rdata >> {off_q, 3'b000};

  always_comb begin
    case (op_q)
      ALU_LB:  ext = {{24{sh[7]}}, sh[7:0]};
      ALU_LH:  ext = {{16{sh[15]}}, sh[15:0]};
      ALU_LBU: ext = {24'h0, sh[7:0]};
      ALU_LHU: ext = {16'h0, sh[15:0]};
      default: ext = sh;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      op_q          <= '0;
      off_q         <= '0;
      rd_q          <= '0;
      wb_valid_q    <= 1'b0;
      wb_data_q     <= '0;
      wb_rd_q       <= '0;
      fault_valid_q <= 1'b0;
      fault_store_q <= 1'b0;
      fault_addr_q  <= '0;
    end else begin
      fault_valid_q <= acc && bad;
      if (acc && bad) begin
        fault_store_q <= is_st;
        fault_addr_q  <= bus.addr;
      end
      if (go_ld) begin
        op_q  <= bus.alucode;
        off_q <= bus.addr[1:0];
        rd_q  <= bus.rd;
      end
      unique case (state)
        IDLE: begin
          if (go_ld) state <= LOAD_WAIT;
        end
        LOAD_WAIT: begin
          wb_data_q  <= ext;
          wb_rd_q    <= rd_q;
          wb_valid_q <= 1'b1;
          state      <= RESP;
        end
        RESP: begin
          if (bus.wb_ready) begin
            wb_valid_q <= 1'b0;
            state      <= go_ld ? LOAD_WAIT : IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.wb_valid    = wb_valid_q;
  assign bus.wb_data     = wb_data_q;
  assign bus.wb_rd       = wb_rd_q;
  assign bus.fault_valid = fault_valid_q;
  assign bus.fault_store = fault_store_q;
  assign bus.fault_addr  = fault_addr_q;
endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a behavioural byte-enabled RAM.
// Drives at posedge+1, checks registered outputs there, comb outputs at +2.
module tb_load_store_unit;
  localparam logic [5:0] LB  = 6'd16;
  localparam logic [5:0] LH  = 6'd17;
  localparam logic [5:0] LW  = 6'd18;
  localparam logic [5:0] LBU = 6'd19;
  localparam logic [5:0] LHU = 6'd20;
  localparam logic [5:0] SB  = 6'd21;
  localparam logic [5:0] SH  = 6'd22;
  localparam logic [5:0] SW  = 6'd23;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   passed = 0;
  int   fails = 0;

  load_store_unit_if #(.ADDR_W(17)) bus ();

  load_store_unit #(.ADDR_W(17)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [0:32767];

  always @(posedge clk) begin
    if (bus.dmem_en) begin
      for (int b = 0; b < 4; b++)
        if (bus.dmem_we[b])
          mem[bus.dmem_addr][8*b +: 8] <= bus.dmem_wdata[8*b +: 8];
      bus.dmem_rdata <= mem[bus.dmem_addr];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [5:0] op, input logic [31:0] a,
                       input logic [31:0] d, input logic [4:0] r);
    bus.req_valid  = 1'b1;
    bus.alucode    = op;
    bus.addr       = a;
    bus.store_data = d;
    bus.rd         = r;
  endtask

  task automatic idle();
    bus.req_valid = 1'b0;
    bus.alucode   = 6'd0;
  endtask

  task automatic do_load(input string tag, input logic [5:0] op,
                         input logic [31:0] a, input logic [4:0] r,
                         input logic [31:0] exp);
    drive(op, a, 32'h0, r);
    #1;
    chk({tag, "_en"}, 32'(bus.dmem_en), 32'd1);
    tick();
    idle();
    tick();
    chk({tag, "_wbv"}, 32'(bus.wb_valid), 32'd1);
    chk({tag, "_data"}, bus.wb_data, exp);
    chk({tag, "_rd"}, 32'(bus.wb_rd), 32'(r));
  endtask

  task automatic do_fault(input string tag, input logic [5:0] op,
                          input logic [31:0] a, input logic st);
    drive(op, a, 32'hA5A5A5A5, 5'd1);
    #1;
    chk({tag, "_en"}, 32'(bus.dmem_en), 32'd0);
    tick();
    idle();
    chk({tag, "_fv"}, 32'(bus.fault_valid), 32'd1);
    chk({tag, "_fa"}, bus.fault_addr, a);
    chk({tag, "_fs"}, 32'(bus.fault_store), 32'(st));
    chk({tag, "_wbv"}, 32'(bus.wb_valid), 32'd0);
    tick();
    chk({tag, "_fv0"}, 32'(bus.fault_valid), 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 32768; i++) mem[i] = 32'h0;
    bus.dmem_rdata = 32'h0;
    bus.wb_ready   = 1'b1;
    bus.store_data = 32'h0;
    bus.addr       = 32'h0;
    bus.rd         = 5'd0;
    idle();

    tick();
    tick();
    chk("rst_ready", 32'(bus.req_ready), 32'd0);
    chk("rst_wbv", 32'(bus.wb_valid), 32'd0);
    chk("rst_fv", 32'(bus.fault_valid), 32'd0);
    chk("rst_en", 32'(bus.dmem_en), 32'd0);
    rst_n = 1'b1;
    tick();

    // SW then LW at the following cycle
    drive(SW, 32'h100, 32'hDEADBEEF, 5'd0);
    #1;
    chk("sw_ready", 32'(bus.req_ready), 32'd1);
    chk("sw_en", 32'(bus.dmem_en), 32'd1);
    chk("sw_we", 32'(bus.dmem_we), 32'hF);
    chk("sw_addr", 32'(bus.dmem_addr), 32'h40);
    chk("sw_wdata", bus.dmem_wdata, 32'hDEADBEEF);
    tick();
    drive(LW, 32'h100, 32'h0, 5'd5);
    #1;
    chk("lw_we", 32'(bus.dmem_we), 32'h0);
    tick();
    idle();
    chk("lw_wait_ready", 32'(bus.req_ready), 32'd0);
    chk("lw_wait_wbv", 32'(bus.wb_valid), 32'd0);
    tick();
    chk("lw_wbv", 32'(bus.wb_valid), 32'd1);
    chk("lw_data", bus.wb_data, 32'hDEADBEEF);
    chk("lw_rd", 32'(bus.wb_rd), 32'd5);

    do_load("lb", LB, 32'h103, 5'd6, 32'hFFFFFFDE);
    do_load("lbu", LBU, 32'h103, 5'd7, 32'h000000DE);
    do_load("lh", LH, 32'h102, 5'd8, 32'hFFFFDEAD);
    do_load("lhu", LHU, 32'h100, 5'd9, 32'h0000BEEF);

    drive(SB, 32'h101, 32'h00000055, 5'd0);
    #1;
    chk("sb_we", 32'(bus.dmem_we), 32'h2);
    chk("sb_wdata", bus.dmem_wdata, 32'h55555555);
    tick();
    idle();
    chk("sb_wbv", 32'(bus.wb_valid), 32'd0);
    do_load("lw_sb", LW, 32'h100, 5'd10, 32'hDEAD55EF);

    do_fault("f_lw", LW, 32'h102, 1'b0);
    do_fault("f_sh", SH, 32'h105, 1'b1);
    do_fault("f_oor", LW, 32'h00020000, 1'b0);
    do_load("f_mem", LW, 32'h100, 5'd11, 32'hDEAD55EF);
    do_load("f_mem2", LW, 32'h104, 5'd12, 32'h00000000);

    // Non-memory opcode is dropped silently
    drive(6'd3, 32'h101, 32'h0, 5'd1);
    #1;
    chk("nop_en", 32'(bus.dmem_en), 32'd0);
    tick();
    idle();
    chk("nop_fv", 32'(bus.fault_valid), 32'd0);

    // Backpressure then back-to-back accept
    bus.wb_ready = 1'b0;
    drive(LW, 32'h100, 32'h0, 5'd13);
    tick();
    idle();
    tick();
    drive(LHU, 32'h102, 32'h0, 5'd14);
    for (int c = 0; c < 5; c++) begin
      #1;
      chk("bp_wbv", 32'(bus.wb_valid), 32'd1);
      chk("bp_data", bus.wb_data, 32'hDEAD55EF);
      chk("bp_rd", 32'(bus.wb_rd), 32'd13);
      chk("bp_ready", 32'(bus.req_ready), 32'd0);
      chk("bp_en", 32'(bus.dmem_en), 32'd0);
      tick();
    end
    bus.wb_ready = 1'b1;
    #1;
    chk("bp2_ready", 32'(bus.req_ready), 32'd1);
    chk("bp2_en", 32'(bus.dmem_en), 32'd1);
    tick();
    idle();
    chk("bp2_wbv0", 32'(bus.wb_valid), 32'd0);
    tick();
    chk("bp2_wbv", 32'(bus.wb_valid), 32'd1);
    chk("bp2_data", bus.wb_data, 32'h0000DEAD);
    chk("bp2_rd", 32'(bus.wb_rd), 32'd14);
    tick();

    // Reset while a load is in LOAD_WAIT
    drive(LW, 32'h100, 32'h0, 5'd3);
    tick();
    idle();
    rst_n = 1'b0;
    #1;
    chk("mr_wbv", 32'(bus.wb_valid), 32'd0);
    chk("mr_data", bus.wb_data, 32'h0);
    chk("mr_rd", 32'(bus.wb_rd), 32'd0);
    chk("mr_ready", 32'(bus.req_ready), 32'd0);
    chk("mr_en", 32'(bus.dmem_en), 32'd0);
    tick();
    chk("mr_wbv2", 32'(bus.wb_valid), 32'd0);
    rst_n = 1'b1;
    tick();
    chk("mr_wbv3", 32'(bus.wb_valid), 32'd0);
    do_load("post_rst", LW, 32'h100, 5'd4, 32'hDEAD55EF);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: observed hang expected finish");
    $fatal(1, "timeout");
  end
endmodule
